// File: rtl/count_source_if.sv
// count_source_if: stimulus-side control inputs and capture-side outputs of the count source
interface count_source_if;
  logic       start;
  logic [3:0] seed;
  logic [3:0] burst_len;
  logic       next;
  logic       dir;
  logic [3:0] inc_step;
  logic [3:0] dec_step;
  logic [3:0] data_out;
  logic       enable;
  logic       busy;
  logic       done;
  modport master (
    output start, seed, burst_len, next, dir, inc_step, dec_step,
    input  data_out, enable, busy, done
  );
  modport slave (
    input  start, seed, burst_len, next, dir, inc_step, dec_step,
    output data_out, enable, busy, done
  );
endinterface

// File: rtl/count_source.sv
// count_source: bounded burst of up/down stepped 4-bit values, one per synchronized next edge
module count_source #(
  parameter bit WRAP        = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input logic          clock1,
  input logic          rst,
  count_source_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;
  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic [3:0]             acc_q;
  logic [3:0]             dout_q;
  logic [4:0]             cnt_q;
  logic                   en_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   edge_d;
  logic [4:0]             sum_d;
  logic [4:0]             diff_d;
  logic [3:0]             step_d;
  // next is asynchronous: resynchronize it, then keep one history flop for rise detection
  always_ff @(posedge clock1)
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.next};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  // next accumulator value; the fifth bit is the carry/borrow that selects wrap or clamp
  always_comb begin
    edge_d = sync_q[SYNC_STAGES-1] & ~hist_q;
    sum_d  = {1'b0, acc_q} + {1'b0, bus.inc_step};
    diff_d = {1'b0, acc_q} - {1'b0, bus.dec_step};
    step_d = bus.dir ? (diff_d[4] ? (WRAP ? diff_d[3:0] : 4'd0) : diff_d[3:0])
                     : (sum_d[4]  ? (WRAP ? sum_d[3:0]  : 4'd15) : sum_d[3:0]);
  end
  // burst control; data_out is a separate register so loading a seed never disturbs it
  always_ff @(posedge clock1)
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= 4'd0;
      dout_q  <= 4'd0;
      cnt_q   <= 5'd0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      en_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE:
          if (bus.start) begin
            acc_q   <= bus.seed;
            cnt_q   <= (bus.burst_len == 4'd0) ? 5'd16 : {1'b0, bus.burst_len};
            busy_q  <= 1'b1;
            state_q <= ARMED;
          end
        ARMED:
          if (edge_d) begin
            acc_q  <= step_d;
            dout_q <= step_d;
            en_q   <= 1'b1;
            cnt_q  <= cnt_q - 5'd1;
            if (cnt_q == 5'd1) state_q <= DONE;
          end
        DONE: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign bus.data_out = dout_q;
  assign bus.enable   = en_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_count_source.sv
// tb_count_source: scoreboard bench running a wrapping and a saturating instance side by side
module tb_count_source;
  localparam int SS = 2;
  logic       clock1 = 1'b0;
  logic       rst;
  logic       start, nxt, dir;
  logic [3:0] seed, blen, inc, dec;
  int         checks = 0;
  int         errors = 0;
  logic [3:0] q_w[$];
  logic [3:0] q_s[$];
  int         n_w = 0;
  int         n_s = 0;
  int         m_cnt = 0;
  logic [3:0] m_w, m_s, last_w, last_s;
  count_source_if a ();
  count_source_if b ();
  assign a.start = start;     assign b.start = start;
  assign a.seed = seed;       assign b.seed = seed;
  assign a.burst_len = blen;  assign b.burst_len = blen;
  assign a.next = nxt;        assign b.next = nxt;
  assign a.dir = dir;         assign b.dir = dir;
  assign a.inc_step = inc;    assign b.inc_step = inc;
  assign a.dec_step = dec;    assign b.dec_step = dec;
  count_source #(.WRAP(1'b1), .SYNC_STAGES(SS)) u_wrap (.clock1(clock1), .rst(rst), .bus(a.slave));
  count_source #(.WRAP(1'b0), .SYNC_STAGES(SS)) u_sat  (.clock1(clock1), .rst(rst), .bus(b.slave));
  always #2 clock1 = ~clock1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  function automatic logic [3:0] model_step(input logic [3:0] acc, input bit wrap);
    int v;
    v = dir ? int'(acc) - int'(dec) : int'(acc) + int'(inc);
    if (wrap) return 4'(v & 15);
    return (v < 0) ? 4'd0 : (v > 15) ? 4'd15 : 4'(v);
  endfunction
  always @(negedge clock1) begin
    if (a.enable === 1'b1) begin
      n_w++;
      if (q_w.size() == 0) chk("sb_wrap_unexpected", 1, 0);
      else chk("sb_wrap_data", a.data_out, q_w.pop_front());
    end
    if (b.enable === 1'b1) begin
      n_s++;
      if (q_s.size() == 0) chk("sb_sat_unexpected", 1, 0);
      else chk("sb_sat_data", b.data_out, q_s.pop_front());
    end
  end
  task automatic start_burst(input logic [3:0] s, input logic [3:0] len);
    start = 1'b1;
    seed  = s;
    blen  = len;
    m_cnt = (len == 4'd0) ? 16 : int'(len);
    m_w   = s;
    m_s   = s;
    @(posedge clock1);
    #1;
    start = 1'b0;
    chk("start_busy", {a.busy, b.busy}, 2'b11);
    chk("start_no_strobe", {a.enable, b.enable}, 2'b00);
  endtask
  task automatic pulse();
    bit exp, last;
    exp  = (m_cnt != 0);
    last = (m_cnt == 1);
    if (exp) begin
      m_w = model_step(m_w, 1'b1);
      m_s = model_step(m_s, 1'b0);
      q_w.push_back(m_w);
      q_s.push_back(m_s);
      last_w = m_w;
      last_s = m_s;
      m_cnt--;
    end
    nxt = 1'b1;
    repeat (SS) @(posedge clock1);
    #1;
    chk("latency_early", {a.enable, b.enable}, 2'b00);
    @(posedge clock1);
    #1;
    chk("latency_strobe", {a.enable, b.enable}, {exp, exp});
    @(posedge clock1);
    #1;
    chk("strobe_width", {a.enable, b.enable}, 2'b00);
    chk("done_pulse", {a.done, b.done}, {last, last});
    chk("busy_after", {a.busy, b.busy}, {2{exp && !last}});
    nxt = 1'b0;
    repeat (4) @(posedge clock1);
    #1;
    chk("done_cleared", {a.done, b.done}, 2'b00);
  endtask
  initial begin
    int nw0;
    rst = 1'b1;
    start = 1'b0; nxt = 1'b0; dir = 1'b0;
    seed = 4'd0; blen = 4'd0; inc = 4'd0; dec = 4'd0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock1);
      #1;
      start = ~start;
      nxt   = ~nxt;
      seed  = 4'(i + 5);
      chk("reset_outputs_wrap", {a.data_out, a.enable, a.busy, a.done}, 7'd0);
      chk("reset_outputs_sat",  {b.data_out, b.enable, b.busy, b.done}, 7'd0);
    end
    rst = 1'b0; start = 1'b0; nxt = 1'b0;
    @(posedge clock1);
    #1;
    chk("post_reset_idle", {a.busy, a.enable, b.busy, b.enable}, 4'd0);
    // up count: wrap gives 1,4,7 and saturate pins at 15
    dir = 1'b0; inc = 4'd3; dec = 4'd0;
    nw0 = n_w;
    start_burst(4'd14, 4'd3);
    chk("seed_not_on_output", a.data_out, 4'd0);
    repeat (3) pulse();
    chk("up_strobes", n_w - nw0, 3);
    chk("up_last_wrap", a.data_out, 4'd7);
    // down count: saturate gives 1,0,0
    dir = 1'b1; dec = 4'd4;
    nw0 = n_s;
    start_burst(4'd5, 4'd3);
    repeat (3) pulse();
    chk("down_strobes", n_s - nw0, 3);
    chk("down_last_sat", b.data_out, 4'd0);
    // extra edges after the burst with a zero step
    dir = 1'b0; inc = 4'd0;
    nw0 = n_w;
    start_burst(4'd3, 4'd2);
    repeat (4) pulse();
    chk("extra_strobes", n_w - nw0, 2);
    chk("extra_hold_wrap", a.data_out, last_w);
    chk("extra_hold_sat", b.data_out, last_s);
    chk("extra_busy", {a.busy, b.busy}, 2'b00);
    // burst_len 0 means 16 steps
    inc = 4'd1;
    nw0 = n_w;
    start_burst(4'd0, 4'd0);
    repeat (17) pulse();
    chk("len0_strobes_wrap", n_w - nw0, 16);
    chk("len0_last_wrap", a.data_out, 4'd0);
    chk("len0_last_sat", b.data_out, 4'd15);
    // reset mid-burst aborts with no further strobes
    inc = 4'd5;
    start_burst(4'd2, 4'd4);
    repeat (2) pulse();
    rst = 1'b1;
    repeat (2) @(posedge clock1);
    #1;
    rst = 1'b0;
    m_cnt = 0;
    nw0 = n_w;
    chk("abort_outputs_wrap", {a.data_out, a.enable, a.busy, a.done}, 7'd0);
    chk("abort_outputs_sat",  {b.data_out, b.enable, b.busy, b.done}, 7'd0);
    pulse();
    chk("abort_no_strobe", n_w - nw0, 0);
    inc = 4'd1;
    start_burst(4'd9, 4'd1);
    pulse();
    chk("restart_value", {a.data_out, b.data_out}, {4'd10, 4'd10});
    chk("sb_wrap_drained", q_w.size(), 0);
    chk("sb_sat_drained", q_s.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
